// File: rtl/soc1_nios_oci_trace_monitor.sv
// OCI direct-control-trace capture monitor: buffers {count, payload} words in a FWFT
// queue and sequences capture -> drain -> done. States: IDLE | CAPTURE | DRAIN | DONE.
module soc1_nios_oci_trace_monitor #(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16,
  parameter int TOTAL_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_arm,
  input  logic                       i_dct_valid,
  input  logic [DATA_W-1:0]          i_dct_buffer,
  input  logic [COUNT_W-1:0]         i_dct_count,
  input  logic                       i_test_ending,
  input  logic                       i_rd_ready,
  output logic                       o_rd_valid,
  output logic [COUNT_W+DATA_W-1:0]  o_rd_data,
  output logic [$clog2(DEPTH):0]     o_fill_level,
  output logic                       o_capturing,
  output logic                       o_test_has_ended,
  output logic [TOTAL_W-1:0]         o_total_count,
  output logic [TOTAL_W-1:0]         o_drop_count
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int FILL_W  = PTR_W + 1;
  localparam int ENTRY_W = COUNT_W + DATA_W;

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN, ST_DONE} state_t;

  state_t               r_state;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [FILL_W-1:0]    r_fill;
  logic                 r_rd_valid;
  logic                 r_capturing;
  logic                 r_done;
  logic [TOTAL_W-1:0]   r_total;
  logic [TOTAL_W-1:0]   r_drop;

  logic                 w_full;
  logic                 w_pop;
  logic                 w_cand;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_arm_start;
  logic [FILL_W-1:0]    w_fill_nxt;
  logic [TOTAL_W:0]     w_total_sum;
  logic [TOTAL_W-1:0]   w_total_nxt;

  assign w_full      = (r_fill == FILL_W'(DEPTH));
  assign w_pop       = r_rd_valid && i_rd_ready && (r_state != ST_IDLE);
  assign w_cand      = (r_state == ST_CAPTURE) && i_dct_valid && (i_dct_count != '0);
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign w_push      = w_cand && (!w_full || w_pop);
  assign w_drop      = w_cand && !w_push;
  assign w_arm_start = i_arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_total_sum = {1'b0, r_total} + (TOTAL_W+1)'(i_dct_count);
  assign w_total_nxt = w_total_sum[TOTAL_W] ? '1 : w_total_sum[TOTAL_W-1:0];

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop)
      w_fill_nxt = r_fill + FILL_W'(1);
    else if (!w_push && w_pop)
      w_fill_nxt = r_fill - FILL_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {i_dct_count, i_dct_buffer};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_rd_valid  <= 1'b0;
      r_capturing <= 1'b0;
      r_done      <= 1'b0;
      r_total     <= '0;
      r_drop      <= '0;
    end else if (w_arm_start) begin
      r_state     <= ST_CAPTURE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_rd_valid  <= 1'b0;
      r_capturing <= 1'b1;
      r_done      <= 1'b0;
      r_total     <= '0;
      r_drop      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_total  <= w_total_nxt;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_drop && (r_drop != '1))
        r_drop <= r_drop + TOTAL_W'(1);
      r_fill     <= w_fill_nxt;
      r_rd_valid <= (w_fill_nxt != '0);
      case (r_state)
        ST_CAPTURE: if (i_test_ending) begin
          r_state     <= ST_DRAIN;
          r_capturing <= 1'b0;
        end
        // Uses the post-pop level so the last pop and the DONE entry share an edge.
        ST_DRAIN: if (w_fill_nxt == '0) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_rd_valid       = r_rd_valid;
  assign o_rd_data        = r_mem[r_rd_ptr];
  assign o_fill_level     = r_fill;
  assign o_capturing      = r_capturing;
  assign o_test_has_ended = r_done;
  assign o_total_count    = r_total;
  assign o_drop_count     = r_drop;
endmodule

// File: tb/tb_soc1_nios_oci_trace_monitor.sv
// Bench for the trace monitor: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_soc1_nios_oci_trace_monitor;
  localparam int DW    = 30;
  localparam int CW    = 4;
  localparam int DEPTH = 16;
  localparam int TW    = 8;
  localparam int TMAX  = (1 << TW) - 1;
  localparam int P_IDLE = 0, P_CAP = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0, arm = 1'b0, dv = 1'b0, te = 1'b0, rdy = 1'b0;
  logic [DW-1:0] dbuf = '0;
  logic [CW-1:0] dcnt = '0;
  logic o_rd_valid, o_capturing, o_test_has_ended;
  logic [CW+DW-1:0] o_rd_data;
  logic [$clog2(DEPTH):0] o_fill_level;
  logic [TW-1:0] o_total_count, o_drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CW+DW-1:0] m_q[$];
  logic [CW+DW-1:0] popped[$];
  int m_phase = P_IDLE;
  int m_total = 0;
  int m_drop  = 0;
  logic [CW+DW-1:0] exp_e;

  soc1_nios_oci_trace_monitor #(.DATA_W(DW), .COUNT_W(CW), .DEPTH(DEPTH), .TOTAL_W(TW)) dut (
    .i_clk(clk), .i_reset(rst), .i_arm(arm), .i_dct_valid(dv), .i_dct_buffer(dbuf),
    .i_dct_count(dcnt), .i_test_ending(te), .i_rd_ready(rdy),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_fill_level(o_fill_level),
    .o_capturing(o_capturing), .o_test_has_ended(o_test_has_ended),
    .o_total_count(o_total_count), .o_drop_count(o_drop_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit pop, cand, acc;
    pop = (m_q.size() > 0) && rdy && (m_phase != P_IDLE);
    if (rst) begin
      m_q.delete(); m_phase = P_IDLE; m_total = 0; m_drop = 0;
    end else if (arm && (m_phase == P_IDLE || m_phase == P_DONE)) begin
      m_q.delete(); m_phase = P_CAP; m_total = 0; m_drop = 0;
    end else begin
      cand = (m_phase == P_CAP) && dv && (dcnt != 0);
      acc  = cand && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back({dcnt, dbuf});
        m_total = (m_total + int'(dcnt) > TMAX) ? TMAX : m_total + int'(dcnt);
      end else if (cand) begin
        m_drop = (m_drop + 1 > TMAX) ? TMAX : m_drop + 1;
      end
      if (m_phase == P_CAP && te) m_phase = P_DRAIN;
      else if (m_phase == P_DRAIN && m_q.size() == 0) m_phase = P_DONE;
    end
  endtask

  task automatic check_all();
    chk("rd_valid", 64'(o_rd_valid), 64'(m_q.size() > 0));
    chk("fill_level", 64'(o_fill_level), 64'(m_q.size()));
    chk("capturing", 64'(o_capturing), 64'(m_phase == P_CAP));
    chk("test_has_ended", 64'(o_test_has_ended), 64'(m_phase == P_DONE));
    chk("total_count", 64'(o_total_count), 64'(m_total));
    chk("drop_count", 64'(o_drop_count), 64'(m_drop));
    if (m_q.size() > 0) chk("rd_data", 64'(o_rd_data), 64'(m_q[0]));
  endtask

  task automatic cyc_full(input bit rs, input bit a, input bit v, input logic [CW-1:0] c,
                          input logic [DW-1:0] b, input bit t, input bit r);
    rst = rs; arm = a; dv = v; dcnt = c; dbuf = b; te = t; rdy = r;
    if (o_rd_valid && r && !rs) popped.push_back(o_rd_data);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cyc(input bit a, input bit v, input logic [CW-1:0] c,
                     input logic [DW-1:0] b, input bit t, input bit r);
    cyc_full(1'b0, a, v, c, b, t, r);
  endtask

  task automatic do_reset();
    cyc_full(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // Scenario 1: basic capture and drain
    do_reset();
    popped.delete();
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 4'd1, 30'h1, 0, 1);
    cyc(0, 1, 4'd2, 30'h2, 0, 1);
    cyc(0, 1, 4'd3, 30'h3, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20 && !o_test_has_ended; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("s1_done", 64'(o_test_has_ended), 64'd1);
    chk("s1_total", 64'(o_total_count), 64'd6);
    chk("s1_npop", 64'(popped.size()), 64'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++) begin
      exp_e = {4'(i + 1), 30'(i + 1)};
      chk("s1_seq", 64'(popped[i]), 64'(exp_e));
    end

    // Scenario 5: re-arm from DONE
    cyc(1, 0, 0, 0, 0, 0);
    chk("s5_capturing", 64'(o_capturing), 64'd1);
    chk("s5_ended", 64'(o_test_has_ended), 64'd0);
    chk("s5_total", 64'(o_total_count), 64'd0);
    chk("s5_drop", 64'(o_drop_count), 64'd0);
    chk("s5_rd_valid", 64'(o_rd_valid), 64'd0);

    // Scenario 2: overflow without reads
    for (int i = 0; i < 20; i++) cyc(0, 1, 4'd1, 30'(i), 0, 0);
    chk("s2_fill", 64'(o_fill_level), 64'd16);
    chk("s2_drop", 64'(o_drop_count), 64'd4);
    chk("s2_total", 64'(o_total_count), 64'd16);
    exp_e = {4'd1, 30'd0};
    chk("s2_head", 64'(o_rd_data), 64'(exp_e));

    // Scenario 3: full buffer with simultaneous push and pop
    cyc(0, 1, 4'd5, 30'h2ABC, 0, 1);
    chk("s3_fill", 64'(o_fill_level), 64'd16);
    chk("s3_drop", 64'(o_drop_count), 64'd4);
    chk("s3_total", 64'(o_total_count), 64'd21);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 1);
    exp_e = {4'd5, 30'h2ABC};
    chk("s3_tail", 64'(o_rd_data), 64'(exp_e));
    chk("s3_fill_last", 64'(o_fill_level), 64'd1);

    // Scenario 4: ignored events
    cyc(0, 1, 4'd0, 30'h7, 0, 0);
    chk("s4_zero_fill", 64'(o_fill_level), 64'd1);
    chk("s4_zero_total", 64'(o_total_count), 64'd21);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s4_arm_cap", 64'(o_capturing), 64'd1);
    chk("s4_arm_fill", 64'(o_fill_level), 64'd1);
    do_reset();
    cyc(0, 0, 0, 0, 1, 0);
    chk("s4_te_idle", 64'(o_capturing), 64'd0);
    chk("s4_te_ended", 64'(o_test_has_ended), 64'd0);
    cyc(0, 1, 4'd3, 30'h5, 0, 0);
    chk("s4_idle_push", 64'(o_fill_level), 64'd0);

    // Scenario 6: reset mid-capture
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 4'd2, 30'(i + 9), 0, 0);
    chk("s6_fill_pre", 64'(o_fill_level), 64'd5);
    do_reset();
    chk("s6_fill", 64'(o_fill_level), 64'd0);
    chk("s6_valid", 64'(o_rd_valid), 64'd0);
    chk("s6_total", 64'(o_total_count), 64'd0);
    chk("s6_cap", 64'(o_capturing), 64'd0);
    cyc(0, 1, 4'd2, 30'h1, 0, 0);
    cyc(0, 1, 4'd2, 30'h2, 0, 0);
    chk("s6_ignored", 64'(o_fill_level), 64'd0);

    // Counter saturation
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 1, 4'd15, 30'(i), 0, 1);
    chk("sat_total", 64'(o_total_count), 64'(TMAX));
    for (int i = 0; i < 300; i++) cyc(0, 1, 4'd1, 30'(i), 0, 0);
    chk("sat_drop", 64'(o_drop_count), 64'(TMAX));

    // Random traffic
    do_reset();
    for (int i = 0; i < 2000; i++)
      cyc_full($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 9) < 7, CW'($urandom_range(0, 15)), DW'($urandom),
               $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/soc1_nios_oci_trace_monitor.md
Name: soc1_nios_oci_trace_monitor

Overview:
Parametrised successor to the NIOS OCI test-bench hook. It captures direct-control-trace (DCT) words from the OCI into a buffer instead of discarding them. Each captured entry is a {dct_count, dct_buffer} word. The block sequences the test-end handshake: capture, then drain, then done. Software or the sim harness pulls captured entries through a valid/ready read port. Drop and total counters are available for end-of-test checking.

Parameters:
DATA_W, 30, width of dct_buffer
COUNT_W, 4, width of dct_count
DEPTH, 16, buffer entries; power of two, >=2
TOTAL_W, 16, width of total_count and drop_count

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
arm  in  1  pulse; starts or restarts a capture session
dct_valid  in  1  dct_buffer/dct_count qualified this cycle
dct_buffer  in  DATA_W  trace payload
dct_count  in  COUNT_W  number of trace items carried in the payload
test_ending  in  1  pulse; stop capture, begin drain
rd_ready  in  1  consumer accepts head entry
rd_valid  out  1  buffer not empty
rd_data  out  COUNT_W+DATA_W  head entry, {count, buffer}
fill_level  out  log2(DEPTH)+1  entries held
capturing  out  1  state == CAPTURE
test_has_ended  out  1  state == DONE
total_count  out  TOTAL_W  saturating sum of dct_count over accepted entries
drop_count  out  TOTAL_W  saturating count of entries rejected because the buffer was full

Behaviour:
- Reset (synchronous, priority over everything):
  - state = IDLE; buffer emptied; pointers = 0.
  - All outputs = 0: rd_valid, fill_level, capturing, test_has_ended, total_count, drop_count. rd_data is don't-care while rd_valid = 0.
- States and transitions:
  - IDLE -> CAPTURE on arm.
  - CAPTURE -> DRAIN on test_ending.
  - DRAIN -> DONE when the buffer is empty; this includes the case where the last entry pops in the current cycle.
  - DONE -> CAPTURE on arm.
  - arm in CAPTURE/DRAIN is ignored. test_ending in IDLE/DRAIN/DONE is ignored.
  - arm from IDLE or DONE clears the buffer, total_count and drop_count in the same edge as entering CAPTURE.
- Push candidate: state == CAPTURE && dct_valid && dct_count != 0.
  - dct_count == 0 entries are ignored and not counted.
  - A push in the same cycle as test_ending is still accepted.
- Push acceptance: candidate && (!full || pop_this_cycle).
  - A simultaneous pop frees a slot, so push-when-full with pop is accepted.
  - On acceptance: total_count += dct_count, saturating at 2^TOTAL_W-1.
  - Candidate not accepted: drop_count += 1, saturating.
- Pop: rd_valid && rd_ready; allowed in every state except IDLE. In IDLE the buffer is empty anyway.
- rd_valid/rd_data: registered buffer head (FWFT).
  - A push at edge N makes rd_valid = 1 after edge N (latency 1) when the buffer was empty.
  - No combinational path from dct_* to rd_*.
- fill_level: +1 on push only, -1 on pop only, unchanged on both; range 0..DEPTH.
- Pointers wrap modulo DEPTH. full = (fill_level == DEPTH).
- test_has_ended holds 1 in DONE until arm or reset.
- Reset asserted mid-capture or mid-drain discards all contents; no partial drain.

Test Plan:
1. Basic capture/drain:
   - Stimulus: reset, arm, then 3 pushes (count=1, 2, 3; buffer=0x1, 0x2, 0x3). Pulse test_ending. Hold rd_ready=1.
   - Response: rd_data sequence {1,0x1},{2,0x2},{3,0x3}; total_count=6; test_has_ended rises the cycle after the third pop.
2. Overflow, no reads:
   - Stimulus: 20 valid pushes of count=1.
   - Response: fill_level=16; drop_count=4; total_count=16; the 17th push does not alter the head.
3. Full with simultaneous pop:
   - Stimulus: buffer at 16 entries; push and pop in the same cycle.
   - Response: fill_level stays 16; drop_count unchanged; new entry appears at tail position.
4. Zero-count and ignored events:
   - Stimulus: dct_valid with count=0; test_ending in IDLE; arm during CAPTURE.
   - Response: fill_level unchanged; state unchanged; counters unchanged.
5. Re-arm from DONE:
   - Stimulus: after scenario 1, pulse arm.
   - Response: capturing=1; test_has_ended=0; total_count=0; drop_count=0; rd_valid=0.
6. Reset mid-operation:
   - Stimulus: 5 entries buffered in CAPTURE; assert reset for 1 cycle.
   - Response: all outputs 0; state IDLE; subsequent dct_valid ignored until arm.
